multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 121 ++++++++++++
 tb/tb_multi_debouncer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: 2-flop synchronizer, per-channel stability
// counter, registered level, press/release edge pulses and optional auto-repeat.
// "release" is a reserved word, so the falling-edge pulse port is release_pulse.
module multi_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 200000,
  parameter int unsigned INVERT        = 0,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] rpt
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [WIDTH-1:0] INV_MASK = {WIDTH{1'(INVERT)}};

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] hit_c;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Two-flop synchronizer; resets to the inactive input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INV_MASK;
      sync2 <= INV_MASK;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
    end
  end

  // Polarity-corrected input, mismatch flags and toggle decisions.
  always_comb begin
    s_c    = sync2 ^ INV_MASK;
    diff_c = s_c ^ out_level;
    hit_c  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      hit_c[i] = diff_c[i] && (cnt[i] == CNT_W'(STABLE_CYCLES - 1));
    end
  end

  // Stability counters, debounced level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
      out_level     <= '0;
      press         <= '0;
      release_pulse <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!diff_c[i] || hit_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      out_level     <= out_level ^ hit_c;
      press         <= hit_c & ~out_level;
      release_pulse <= hit_c & out_level;
    end
  end

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rcnt [WIDTH];
    logic [WIDTH-1:0] started;
    logic [WIDTH-1:0] fire_c;

    // First pulse after the initial delay, then one per period.
    always_comb begin
      fire_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        fire_c[i] = started[i] ? (rcnt[i] == RPT_W'(REPEAT_PERIOD - 1))
                               : (rcnt[i] == RPT_W'(REPEAT_DELAY - 1));
      end
    end

    // Repeat counters run only while held; a falling toggle clears and suppresses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          rcnt[i] <= '0;
        end
        started <= '0;
        rpt     <= '0;
      end else begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (!out_level[i] || hit_c[i]) begin
            rcnt[i]    <= '0;
            started[i] <= 1'b0;
            rpt[i]     <= 1'b0;
          end else if (fire_c[i]) begin
            rcnt[i]    <= '0;
            started[i] <= 1'b1;
            rpt[i]     <= 1'b1;
          end else begin
            rcnt[i]    <= rcnt[i] + RPT_W'(1);
            rpt[i]     <= 1'b0;
          end
        end
      end
    end
  end else begin : g_no_rpt
    assign rpt = '0;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: pulse scoreboard plus inline level checks.
module tb_multi_debouncer;

  localparam int S  = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int LAT = S + 2;  // drive-cycle to pulse-cycle distance

  typedef struct {
    int cyc;
    int kind;  // 0 press, 1 release, 2 rpt
    int ch;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_raw;
  logic [3:0] out_level, press, release_pulse, rpt;
  logic [3:0] in_raw_inv;
  logic [3:0] out_level_inv, press_inv, release_inv, rpt_inv;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   inv_pulses = 0;
  ev_t  exp_q[$];

  multi_debouncer #(
    .WIDTH(4), .STABLE_CYCLES(S), .INVERT(0), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .out_level(out_level),
    .press(press), .release_pulse(release_pulse), .rpt(rpt)
  );

  multi_debouncer #(
    .WIDTH(4), .STABLE_CYCLES(S), .INVERT(1), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw_inv), .out_level(out_level_inv),
    .press(press_inv), .release_pulse(release_inv), .rpt(rpt_inv)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp every pulse.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 4; c++) begin
          logic [3:0] v;
          v = (k == 0) ? press : (k == 1) ? release_pulse : rpt;
          if (v[c]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_pulse: kind=%0d ch=%0d at cycle %0d, none expected", k, c, cyc);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.cyc !== cyc || e.kind != k || e.ch != c) begin
                n_fail++;
                $display("FAIL pulse_event: got kind=%0d ch=%0d cycle=%0d, expected kind=%0d ch=%0d cycle=%0d",
                         k, c, cyc, e.kind, e.ch, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  // Count any edge pulse from the inverted-polarity instance.
  always @(negedge clk) begin
    if (rst_n && ((press_inv | release_inv) != 4'h0)) inv_pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input int kind, input int ch);
    ev_t e;
    e.cyc = c; e.kind = kind; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_events: %0d expected pulses never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    int c0;
    rst_n = 1'b0; in_raw = 4'hF; in_raw_inv = 4'hF;
    step(3);
    n_checks++;
    if ({out_level, press, release_pulse, rpt} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0000", {out_level, press, release_pulse, rpt});
    end
    n_checks++;
    if ({out_level_inv, press_inv, release_inv, rpt_inv} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_inv: got %h, required 0000", {out_level_inv, press_inv, release_inv, rpt_inv});
    end
    rst_n = 1'b1;
    c0 = cyc;
    for (int ch = 0; ch < 4; ch++) push_ev(c0 + LAT, 0, ch);
    step(LAT - 1);
    n_checks++;
    if (out_level !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_early_level: got %h, required 0", out_level);
    end
    step(1);
    n_checks++;
    if (out_level !== 4'hF || press !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_rise: level=%h press=%h, required F/F", out_level, press);
    end
    in_raw = 4'h0;
    for (int ch = 0; ch < 4; ch++) push_ev(cyc + LAT, 1, ch);
    step(1);
    n_checks++;
    if (press !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_press_width: press=%h, required 0", press);
    end
    step(LAT + 2);
    n_checks++;
    if (out_level !== 4'h0 || out_level_inv !== 4'h0 || inv_pulses != 0) begin
      n_fail++;
      $display("FAIL reset_after: level=%h level_inv=%h inv_pulses=%0d, required 0/0/0",
               out_level, out_level_inv, inv_pulses);
    end
    drain_check("reset");
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 3; k++) begin
      in_raw[0] = 1'b1; step(7);
      in_raw[0] = 1'b0; step(2);
    end
    in_raw[0] = 1'b1;
    push_ev(cyc + LAT, 0, 0);
    step(LAT - 1);
    n_checks++;
    if (out_level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_early: level0=%b, required 0", out_level[0]);
    end
    step(1);
    n_checks++;
    if (out_level[0] !== 1'b1 || press[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_rise: level0=%b press0=%b, required 1/1", out_level[0], press[0]);
    end
    in_raw[0] = 1'b0;
    push_ev(cyc + LAT, 1, 0);
    step(LAT + 2);
    drain_check("bounce");
  endtask

  task automatic test_repeat;
    int cp;
    in_raw[2] = 1'b1;
    cp = cyc + LAT;
    push_ev(cp, 0, 2);
    for (int k = 0; k < 4; k++) push_ev(cp + RD + k * RP, 2, 2);
    while (cyc < cp + 30) step(1);
    in_raw[2] = 1'b0;
    push_ev(cp + 40, 1, 2);
    step(40);
    n_checks++;
    if (out_level !== 4'h0) begin
      n_fail++;
      $display("FAIL repeat_level_after: level=%h, required 0", out_level);
    end
    drain_check("repeat");
  endtask

  task automatic test_independence;
    in_raw[3] = 1'b1;
    push_ev(cyc + LAT, 0, 3);
    for (int k = 0; k < 15; k++) begin
      if (k % 3 == 0) in_raw[1] = ~in_raw[1];
      step(1);
      n_checks++;
      if (out_level[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL indep_level1: level1=%b at step %0d, required 0", out_level[1], k);
      end
    end
    n_checks++;
    if (out_level[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL indep_level3: level3=%b, required 1", out_level[3]);
    end
    in_raw[3] = 1'b0; in_raw[1] = 1'b0;
    push_ev(cyc + LAT, 1, 3);
    step(LAT + 2);
    drain_check("indep");
  endtask

  task automatic test_reset_mid;
    in_raw[0] = 1'b1;
    step(7);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    push_ev(cyc + LAT, 0, 0);
    step(LAT - 1);
    n_checks++;
    if (out_level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_early: level0=%b, required 0", out_level[0]);
    end
    step(1);
    n_checks++;
    if (press[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_press: press0=%b, required 1", press[0]);
    end
    in_raw[0] = 1'b0;
    push_ev(cyc + LAT, 1, 0);
    step(LAT + 2);
    drain_check("reset_mid");
  endtask

  task automatic test_invert;
    in_raw_inv = 4'hE;
    step(LAT - 1);
    n_checks++;
    if (out_level_inv !== 4'h0 || press_inv !== 4'h0) begin
      n_fail++;
      $display("FAIL invert_early: level=%h press=%h, required 0/0", out_level_inv, press_inv);
    end
    step(1);
    n_checks++;
    if (out_level_inv !== 4'h1 || press_inv !== 4'h1) begin
      n_fail++;
      $display("FAIL invert_rise: level=%h press=%h, required 1/1", out_level_inv, press_inv);
    end
    step(1);
    n_checks++;
    if (press_inv !== 4'h0 || out_level_inv !== 4'h1 || inv_pulses != 1) begin
      n_fail++;
      $display("FAIL invert_after: press=%h level=%h pulses=%0d, required 0/1/1",
               press_inv, out_level_inv, inv_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_repeat();
    test_independence();
    test_reset_mid();
    test_invert();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
